// File: rtl/main_fifo_pkg.sv
// Shared types and helpers for the main FIFO pop controller.
// Holds the FSM state encoding, the pause-mode selectors and the VC id width helper.
package main_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    localparam int PAUSE_GLOBAL   = 0;
    localparam int PAUSE_PER_DEST = 1;

    // Width of the VC id field; a single channel still needs one bit to address.
    function automatic int vc_id_width(input int num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

endpackage

// File: rtl/vc_dest_decode.sv
// Combinational destination decode of a main FIFO word.
// Produces the VC id, an out-of-range flag and the one-hot push vector.
module vc_dest_decode
    import main_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 6,
    parameter  int NUM_VC     = 2,
    parameter  int VC_SEL_LSB = 4,
    localparam int VCW        = vc_id_width(NUM_VC)
) (
    input  logic [DATA_WIDTH-1:0] word,
    output logic [VCW-1:0]        dest,
    output logic                  bad_dest,
    output logic [NUM_VC-1:0]     onehot
);

    assign dest = word[VC_SEL_LSB +: VCW];

    // Zero-extended compare so the range test also works when NUM_VC fills the field.
    assign bad_dest = {1'b0, dest} >= (VCW + 1)'(NUM_VC);

    assign onehot = bad_dest ? '0 : (NUM_VC'(1) << dest);

endmodule

// File: rtl/main_fifo_pop_ctrl.sv
// Pop controller moving words from the main FIFO into NUM_VC virtual-channel FIFOs,
// with global or per-destination pause, out-of-range drop and stall monitoring.
module main_fifo_pop_ctrl
    import main_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 6,
    parameter int NUM_VC      = 2,
    parameter int VC_SEL_LSB  = 4,
    parameter int PAUSE_MODE  = PAUSE_GLOBAL,
    parameter int STALL_W     = 4,
    parameter int STALL_LIMIT = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  main_empty,
    input  logic [DATA_WIDTH-1:0] main_data,
    input  logic [NUM_VC-1:0]     pause_vc,
    output logic                  pop_main,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [NUM_VC-1:0]     push_vc,
    output logic [1:0]            state,
    output logic [STALL_W-1:0]    stall_count,
    output logic                  stall_flag,
    output logic [7:0]            drop_count
);

    localparam int                 VCW       = vc_id_width(NUM_VC);
    localparam logic [STALL_W-1:0] STALL_MAX = '1;
    localparam logic [STALL_W-1:0] LIMIT     = STALL_W'(STALL_LIMIT);

    logic [VCW-1:0]     dest;
    logic               bad_dest;
    logic [NUM_VC-1:0]  onehot;
    logic               blocked;
    logic               word_ok;
    logic [STALL_W-1:0] stall_next;
    state_t             state_q;
    state_t             state_d;

    vc_dest_decode #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_VC     (NUM_VC),
        .VC_SEL_LSB (VC_SEL_LSB)
    ) u_decode (
        .word     (main_data),
        .dest     (dest),
        .bad_dest (bad_dest),
        .onehot   (onehot)
    );

    // An out-of-range id is never held back in per-destination mode, so it drains.
    assign blocked  = (PAUSE_MODE == PAUSE_PER_DEST) ? (!bad_dest && pause_vc[dest])
                                                     : (|pause_vc);
    assign pop_main = !reset && !main_empty && !blocked;
    assign word_ok  = pop_main && !bad_dest;
    assign state    = state_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (main_empty) begin
            state_d = IDLE;
        end else if (blocked) begin
            state_d = BLOCKED;
        end else begin
            state_d = ACTIVE;
        end
    end

    always_comb begin
        stall_next = stall_count;
        if (main_empty || pop_main) begin
            stall_next = '0;
        end else if (stall_count != STALL_MAX) begin
            stall_next = stall_count + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            data_out    <= '0;
            valid_out   <= 1'b0;
            push_vc     <= '0;
            stall_count <= '0;
            stall_flag  <= 1'b0;
            drop_count  <= '0;
        end else begin
            state_q     <= state_d;
            valid_out   <= word_ok;
            push_vc     <= word_ok ? onehot : '0;
            stall_count <= stall_next;
            // Flag follows the next count so it rises on the same edge the count hits the limit.
            stall_flag  <= (stall_next >= LIMIT);
            if (word_ok) begin
                data_out <= main_data;
            end
            if (pop_main && bad_dest && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_main_fifo_pop_ctrl.sv
// Self-checking bench: a 2-VC global-pause instance and a 3-VC per-destination instance
// share stimulus and are compared against a cycle-level behavioural model.
module tb_main_fifo_pop_ctrl;

    typedef struct packed {
        logic       pop;
        logic       valid;
        logic [5:0] data;
        logic [2:0] push;
        logic [1:0] state;
        logic [3:0] stall;
        logic       flag;
        logic [7:0] drop;
    } snap_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       main_empty;
    logic [5:0] main_data;
    logic [2:0] pause;

    logic       pop_g, valid_g, flag_g;
    logic [5:0] data_g;
    logic [1:0] push_g, state_g;
    logic [3:0] stall_g;
    logic [7:0] drop_g;

    logic       pop_p, valid_p, flag_p;
    logic [5:0] data_p;
    logic [2:0] push_p;
    logic [1:0] state_p;
    logic [3:0] stall_p;
    logic [7:0] drop_p;

    snap_t obs_g, obs_p;
    snap_t mdl [2];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    main_fifo_pop_ctrl #(
        .DATA_WIDTH(6), .NUM_VC(2), .VC_SEL_LSB(4), .PAUSE_MODE(0), .STALL_W(4), .STALL_LIMIT(12)
    ) dut_g (
        .clk(clk), .reset(reset), .main_empty(main_empty), .main_data(main_data),
        .pause_vc(pause[1:0]), .pop_main(pop_g), .data_out(data_g), .valid_out(valid_g),
        .push_vc(push_g), .state(state_g), .stall_count(stall_g), .stall_flag(flag_g),
        .drop_count(drop_g)
    );

    main_fifo_pop_ctrl #(
        .DATA_WIDTH(6), .NUM_VC(3), .VC_SEL_LSB(4), .PAUSE_MODE(1), .STALL_W(4), .STALL_LIMIT(12)
    ) dut_p (
        .clk(clk), .reset(reset), .main_empty(main_empty), .main_data(main_data),
        .pause_vc(pause), .pop_main(pop_p), .data_out(data_p), .valid_out(valid_p),
        .push_vc(push_p), .state(state_p), .stall_count(stall_p), .stall_flag(flag_p),
        .drop_count(drop_p)
    );

    assign obs_g = {pop_g, valid_g, data_g, 1'b0, push_g, state_g, stall_g, flag_g, drop_g};
    assign obs_p = {pop_p, valid_p, data_p, push_p, state_p, stall_p, flag_p, drop_p};

    // Instance 0: 2 VCs, any pause blocks. Instance 1: 3 VCs, only the destination's pause blocks.
    function automatic void decide(input int k, input logic r, input logic e,
                                   input logic [5:0] d, input logic [2:0] p,
                                   output int dest, output bit bad, output bit blk, output bit pop);
        int nvc, vcw, pm;
        nvc  = (k == 1) ? 3 : 2;
        vcw  = (k == 1) ? 2 : 1;
        dest = (int'(d) >> 4) & ((1 << vcw) - 1);
        bad  = (dest >= nvc);
        pm   = int'(p) & ((1 << nvc) - 1);
        if (k == 1) blk = !bad && (((pm >> dest) & 1) == 1);
        else        blk = (pm != 0);
        pop = !r && !e && !blk;
    endfunction

    function automatic snap_t model_next(input int k, input snap_t cur, input logic r,
                                         input logic e, input logic [5:0] d, input logic [2:0] p);
        snap_t n;
        int    dest;
        bit    bad, blk, pop, good;
        decide(k, r, e, d, p, dest, bad, blk, pop);
        if (r) return '0;
        n       = cur;
        good    = pop && !bad;
        n.valid = good;
        n.push  = good ? 3'(1 << dest) : 3'd0;
        if (good) n.data = d;
        if (pop && bad && cur.drop != 8'd255) n.drop = cur.drop + 8'd1;
        n.state = e ? 2'd0 : (blk ? 2'd2 : 2'd1);
        n.stall = (e || pop) ? 4'd0 : ((cur.stall == 4'd15) ? 4'd15 : cur.stall + 4'd1);
        n.flag  = (n.stall >= 4'd12);
        return n;
    endfunction

    task automatic refresh_pop();
        int dest;
        bit bad, blk, pop;
        for (int k = 0; k < 2; k++) begin
            decide(k, reset, main_empty, main_data, pause, dest, bad, blk, pop);
            mdl[k].pop = pop;
        end
    endtask

    // Called just after a falling edge; inputs settle before the next rising edge.
    task automatic drive(input logic r, input logic e, input logic [5:0] d, input logic [2:0] p);
        reset      = r;
        main_empty = e;
        main_data  = d;
        pause      = p;
        #1;
        refresh_pop();
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++)
            mdl[k] = model_next(k, mdl[k], reset, main_empty, main_data, pause);
        @(negedge clk);
        refresh_pop();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 6'h05, 3'b000);
            checks++;
            if (pop_g !== 1'b0 || pop_p !== 1'b0) begin
                failures++;
                $display("FAIL reset_pop c=%0d: pop_g=%b pop_p=%b expected 0", c, pop_g, pop_p);
            end
            tick();
            checks++;
            if (obs_g !== '0 || obs_p !== '0) begin
                failures++;
                $display("FAIL reset_state c=%0d: g=%h p=%h expected all zero", c, obs_g, obs_p);
            end
        end
    endtask

    task automatic test_stream();
        drive(1'b0, 1'b0, 6'h05, 3'b000);
        checks++;
        if (pop_g !== 1'b1) begin
            failures++;
            $display("FAIL stream_pop0: pop_g=%b expected 1", pop_g);
        end
        tick();
        checks++;
        if (valid_g !== 1'b1 || data_g !== 6'h05 || push_g !== 2'b01 || state_g !== 2'd1) begin
            failures++;
            $display("FAIL stream_w0: valid=%b data=%h push=%b state=%0d expected 1 05 01 1",
                     valid_g, data_g, push_g, state_g);
        end
        drive(1'b0, 1'b0, 6'h1A, 3'b000);
        checks++;
        if (pop_g !== 1'b1) begin
            failures++;
            $display("FAIL stream_pop1: pop_g=%b expected 1", pop_g);
        end
        tick();
        checks++;
        if (valid_g !== 1'b1 || data_g !== 6'h1A || push_g !== 2'b10 || state_g !== 2'd1) begin
            failures++;
            $display("FAIL stream_w1: valid=%b data=%h push=%b state=%0d expected 1 1a 10 1",
                     valid_g, data_g, push_g, state_g);
        end
        checks++;
        if (push_p !== 3'b010) begin
            failures++;
            $display("FAIL stream_w1_p: push_p=%b expected 010", push_p);
        end
    endtask

    task automatic test_mode_compare();
        drive(1'b0, 1'b0, 6'h05, 3'b010);
        checks++;
        if (pop_g !== 1'b0 || pop_p !== 1'b1) begin
            failures++;
            $display("FAIL mode_pop: pop_g=%b pop_p=%b expected 0 1", pop_g, pop_p);
        end
        tick();
        checks++;
        if (state_g !== 2'd2 || stall_g !== 4'd1 || valid_g !== 1'b0) begin
            failures++;
            $display("FAIL mode_global: state=%0d stall=%0d valid=%b expected 2 1 0",
                     state_g, stall_g, valid_g);
        end
        checks++;
        if (push_p !== 3'b001 || valid_p !== 1'b1 || state_p !== 2'd1) begin
            failures++;
            $display("FAIL mode_perdest: push=%b valid=%b state=%0d expected 001 1 1",
                     push_p, valid_p, state_p);
        end
    endtask

    task automatic test_stall_saturation();
        drive(1'b0, 1'b1, 6'h05, 3'b001);
        tick();
        checks++;
        if (state_g !== 2'd0 || stall_g !== 4'd0) begin
            failures++;
            $display("FAIL stall_clear_empty: state=%0d stall=%0d expected 0 0", state_g, stall_g);
        end
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 1'b0, 6'h05, 3'b001);
            checks++;
            if (pop_g !== 1'b0 || pop_p !== 1'b0) begin
                failures++;
                $display("FAIL stall_pop k=%0d: pop_g=%b pop_p=%b expected 0", k, pop_g, pop_p);
            end
            tick();
            checks++;
            if (stall_g !== 4'((k > 15) ? 15 : k) || flag_g !== (k >= 12) ||
                stall_p !== 4'((k > 15) ? 15 : k) || flag_p !== (k >= 12)) begin
                failures++;
                $display("FAIL stall_count k=%0d: g=%0d/%b p=%0d/%b expected %0d/%b", k,
                         stall_g, flag_g, stall_p, flag_p, (k > 15) ? 15 : k, k >= 12);
            end
        end
        drive(1'b0, 1'b0, 6'h05, 3'b000);
        checks++;
        if (pop_g !== 1'b1) begin
            failures++;
            $display("FAIL stall_release_pop: pop_g=%b expected 1", pop_g);
        end
        tick();
        checks++;
        if (stall_g !== 4'd0 || flag_g !== 1'b0 || valid_g !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: stall=%0d flag=%b valid=%b expected 0 0 1",
                     stall_g, flag_g, valid_g);
        end
    endtask

    task automatic test_bad_dest();
        drive(1'b0, 1'b0, 6'h35, 3'b000);
        checks++;
        if (pop_p !== 1'b1) begin
            failures++;
            $display("FAIL bad_pop: pop_p=%b expected 1", pop_p);
        end
        tick();
        checks++;
        if (valid_p !== 1'b0 || push_p !== 3'b000 || drop_p !== 8'd1 || data_p !== 6'h05) begin
            failures++;
            $display("FAIL bad_drop: valid=%b push=%b drop=%0d data=%h expected 0 000 1 05",
                     valid_p, push_p, drop_p, data_p);
        end
        drive(1'b0, 1'b0, 6'h25, 3'b111);
        checks++;
        if (pop_p !== 1'b0) begin
            failures++;
            $display("FAIL bad_good_paused: pop_p=%b expected 0", pop_p);
        end
        drive(1'b0, 1'b0, 6'h35, 3'b111);
        checks++;
        if (pop_p !== 1'b1) begin
            failures++;
            $display("FAIL bad_ignores_pause: pop_p=%b expected 1", pop_p);
        end
        tick();
        checks++;
        if (drop_p !== 8'd2) begin
            failures++;
            $display("FAIL bad_drop2: drop=%0d expected 2", drop_p);
        end
        drive(1'b0, 1'b0, 6'h25, 3'b000);
        tick();
        checks++;
        if (valid_p !== 1'b1 || push_p !== 3'b100 || data_p !== 6'h25 || drop_p !== 8'd2) begin
            failures++;
            $display("FAIL bad_continue: valid=%b push=%b data=%h drop=%0d expected 1 100 25 2",
                     valid_p, push_p, data_p, drop_p);
        end
    endtask

    task automatic test_midstream_reset();
        drive(1'b0, 1'b0, 6'h05, 3'b000);
        tick();
        checks++;
        if (valid_g !== 1'b1) begin
            failures++;
            $display("FAIL mrst_pre: valid_g=%b expected 1", valid_g);
        end
        drive(1'b1, 1'b0, 6'h05, 3'b000);
        checks++;
        if (pop_g !== 1'b0 || pop_p !== 1'b0) begin
            failures++;
            $display("FAIL mrst_pop: pop_g=%b pop_p=%b expected 0", pop_g, pop_p);
        end
        tick();
        checks++;
        if (valid_g !== 1'b0 || valid_p !== 1'b0 || drop_p !== 8'd0 || state_g !== 2'd0) begin
            failures++;
            $display("FAIL mrst_post: valid_g=%b valid_p=%b drop=%0d state=%0d expected 0 0 0 0",
                     valid_g, valid_p, drop_p, state_g);
        end
    endtask

    task automatic test_drop_saturation();
        for (int c = 0; c < 260; c++) begin
            drive(1'b0, 1'b0, 6'h30 | 6'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            tick();
        end
        checks++;
        if (drop_p !== 8'd255 || valid_p !== 1'b0) begin
            failures++;
            $display("FAIL drop_sat: drop=%0d valid=%b expected 255 0", drop_p, valid_p);
        end
    endtask

    task automatic test_random();
        snap_t o;
        for (int c = 0; c < 500; c++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                  6'($urandom), {($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3),
                                 ($urandom_range(0, 9) < 3)});
            for (int k = 0; k < 2; k++) begin
                o = (k == 1) ? obs_p : obs_g;
                checks++;
                if (o.pop !== mdl[k].pop) begin
                    failures++;
                    $display("FAIL rand_pop k=%0d cyc=%0d: got %b expected %b", k, c, o.pop, mdl[k].pop);
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                o = (k == 1) ? obs_p : obs_g;
                checks++;
                if (o !== mdl[k]) begin
                    failures++;
                    $display("FAIL rand_regs k=%0d cyc=%0d: got %h expected %h", k, c, o, mdl[k]);
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        main_empty = 1'b1;
        main_data  = '0;
        pause      = '0;
        mdl[0]     = '0;
        mdl[1]     = '0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_mode_compare();
        test_stall_saturation();
        test_bad_dest();
        test_midstream_reset();
        test_drop_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/main_fifo_pop_ctrl.md
# main_fifo_pop_ctrl

Parametrised pop controller between the main FIFO and the NUM_VC virtual-channel FIFOs. When the main FIFO is non-empty, it decodes the destination VC from the head word and pops it unless the relevant pause flags block the pop. The popped word is registered with a valid strobe and a one-hot VC push. Beyond the fixed 2-channel, global-pause behaviour, it adds a per-destination pause mode, handling for out-of-range VC ids, and stall/drop monitoring.

## Interface
Parameters:
- DATA_WIDTH, 6: main FIFO word width.
- NUM_VC, 2: number of virtual channels, ≥2.
- VC_SEL_LSB, 4: LSB position of the VC id field in the word. The field width is VCW = $clog2(NUM_VC), and VC_SEL_LSB+VCW ≤ DATA_WIDTH.
- PAUSE_MODE, 0:
  - 0 = global: any pause bit set blocks the pop.
  - 1 = per-destination: only pause_vc[dest] blocks the pop.
- STALL_W, 4: stall counter width.
- STALL_LIMIT, 12: stalled-cycle threshold for stall_flag. Must be < 2^STALL_W.

Ports:
- clk  in  1  sole clock; all state on posedge.
- reset  in  1  synchronous, active-high reset.
- main_empty  in  1  main FIFO empty.
- main_data  in  DATA_WIDTH  main FIFO head word, first-word-fall-through; valid whenever !main_empty.
- pause_vc  in  NUM_VC  per-VC almost-full pause.
- pop_main  out  1  combinational pop to the main FIFO.
- data_out  out  DATA_WIDTH  registered popped word.
- valid_out  out  1  registered: data_out is valid this cycle.
- push_vc  out  NUM_VC  registered one-hot push to the destination VC FIFO.
- state  out  2  FSM state.
- stall_count  out  STALL_W  consecutive blocked cycles, saturating.
- stall_flag  out  1  stall_count ≥ STALL_LIMIT.
- drop_count  out  8  words dropped for an out-of-range VC id, saturating.

## Operation
- dest = main_data[VC_SEL_LSB +: VCW]. bad_dest = (dest ≥ NUM_VC).
- blocked:
  - Mode 0: |pause_vc.
  - Mode 1: !bad_dest && pause_vc[dest].
- pop_main = !reset && !main_empty && !blocked. Purely combinational, with no added latency.
- Cycle after a pop:
  - Good dest: valid_out=1, data_out=main_data (captured), push_vc=1<<dest.
  - bad_dest: the word is popped and discarded. valid_out=0, push_vc=0, drop_count+1, saturating at 255.
- Cycle after no pop: valid_out=0 and push_vc=0. data_out holds its last value.
- FSM states:
  - IDLE (0): main_empty.
  - ACTIVE (1): a pop occurred in the previous cycle.
  - BLOCKED (2): non-empty and blocked in the previous cycle.
- FSM next state from current inputs each cycle:
  - main_empty → IDLE.
  - else blocked → BLOCKED.
  - else → ACTIVE.
  - Any state can go to any state.
- stall_count:
  - +1 each cycle where !main_empty && blocked, saturating at 2^STALL_W−1.
  - Cleared on any pop or when main_empty.
- stall_flag is registered and derived from the next stall_count value, so it asserts in the same cycle the count reaches STALL_LIMIT.
- Reset values: valid_out=0, push_vc=0, data_out=0, state=IDLE, stall_count=0, stall_flag=0, drop_count=0. pop_main=0 while reset is high.

## Timing
- Pop → valid_out/push_vc/data_out: 1 cycle.
- Sustained throughput: 1 word/cycle.
- pause_vc is sampled in the same cycle as the pop decision. A pause asserted in cycle N suppresses the pop in cycle N.
- Because one word can still land after pause asserts, VC FIFOs must raise pause with ≥1 free slot.
- main_empty and pause changing in the same cycle: empty has priority (no pop, state IDLE, counter cleared).
- Reset asserted mid-stream: in the cycle reset is high, there is no pop. The word popped in the previous cycle is lost from the outputs (valid_out=0 on the next edge). The upstream FIFO is reset together with this block.

## Structure
- Package main_fifo_pkg:
  - State enum: IDLE=2'd0, ACTIVE=2'd1, BLOCKED=2'd2.
  - PAUSE_GLOBAL=0, PAUSE_PER_DEST=1.
  - A function returning the VC id width from NUM_VC.
- Sub-module vc_dest_decode: extracts dest, bad_dest and the one-hot vector from the word. It is combinational and parametrised like the parent.
- Counters and FSM stay in the top module.

## Test plan
- Reset: hold reset 3 cycles with main_empty=0, pause=0 → pop_main=0 throughout; all outputs at reset values; state=IDLE.
- Streaming, NUM_VC=2, mode 0: words 6'h05 then 6'h1A, no pause → pop_main=1 for 2 cycles. Next cycles: valid_out=1 with data_out 6'h05, push_vc=2'b01; then 6'h1A, push_vc=2'b10; state=ACTIVE.
- Mode comparison: pause_vc=2'b10 with head 6'h05 (dest 0):
  - Mode 0: no pop, state=BLOCKED, stall_count increments.
  - Mode 1: pop, push_vc=2'b01 next cycle.
- Stall saturation, STALL_W=4, LIMIT=12: blocked for 20 cycles → stall_flag rises at count 12; count holds at 15. Releasing pause → a pop occurs and the count clears to 0.
- Bad dest, NUM_VC=3: head with dest field 3 → popped, valid_out=0 and push_vc=0 next cycle, drop_count=1; stream continues.
- Mid-stream reset: pop in cycle N, reset in cycle N+1 → valid_out=0 at N+2 and drop_count=0.
